// File: rtl/muldiv_hilo.sv
// muldiv_hilo: multi-cycle multiply/divide unit holding the architectural
// HI/LO registers. Sits beside the ALU in EX; busy stalls IF/ID/EX.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset
//   start  in   request valid this cycle
//   op     in   000 none, 001 mult, 010 multu, 011 div, 100 divu,
//               101 mthi, 110 mtlo, 111 reserved
//   a      in   rs operand (dividend / multiplicand / mthi-mtlo source)
//   b      in   rt operand (divisor / multiplier)
//   hi/lo  out  HI/LO registers
//   busy   out  high while a mult/div is in flight (registered)
//   done   out  one-cycle pulse when HI/LO take a mult/div result
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t state, state_nx;

  logic [CW-1:0]      cnt;
  logic [2:0]         op_r;
  logic               sign_a, sign_b, b_zero;
  logic [WIDTH-1:0]   a_orig, mag_a, mag_b;
  // mult: {partial product high, multiplier shifting out the bottom}
  // div : {remainder, dividend shifting into quotient}
  logic [2*WIDTH-1:0] acc;

  // decode / datapath signals
  logic               is_md, accept, mthi_we, mtlo_we, last_iter;
  logic               op_signed, in_sa, in_sb;
  logic [WIDTH-1:0]   in_mag_a, in_mag_b;
  logic               r_is_mul;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, acc_next, prod;
  logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept)    state_nx = S_CALC;
      S_CALC: if (last_iter) state_nx = S_FIX;
      S_FIX:                 state_nx = S_IDLE;
      default:               state_nx = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- decode + datapath
  always_comb begin
    is_md     = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    accept    = (state == S_IDLE) && start && is_md;
    mthi_we   = (state == S_IDLE) && start && (op == OP_MTHI);
    mtlo_we   = (state == S_IDLE) && start && (op == OP_MTLO);
    last_iter = (cnt == CW'(WIDTH-1));

    // Unsigned ops latch operands as-is with both signs forced to zero,
    // so the FIX stage never negates them.
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    in_sa     = op_signed & a[WIDTH-1];
    in_sb     = op_signed & b[WIDTH-1];
    in_mag_a  = in_sa ? -a : a;
    in_mag_b  = in_sb ? -b : b;

    // shift-add: add multiplicand into the top half when the multiplier
    // LSB is set, then shift the whole accumulator right by one
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};

    // restoring divide: shift next dividend bit into the remainder and keep
    // the subtraction only if it did not go negative
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, mag_b};
    div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

    r_is_mul  = (op_r == OP_MULT) || (op_r == OP_MULTU);
    acc_next  = r_is_mul ? mul_next : div_next;

    // write-back values for FIX
    prod = (sign_a ^ sign_b) ? -acc : acc;
    quo  = acc[WIDTH-1:0];
    rem  = acc[2*WIDTH-1:WIDTH];
    if (r_is_mul) begin
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end else if (b_zero) begin
      // divide by zero: quotient all ones, remainder is the raw dividend
      fix_hi = a_orig;
      fix_lo = '1;
    end else begin
      // 0x80..0 / -1 wraps naturally to 0x80..0 through the negation
      fix_lo = (sign_a ^ sign_b) ? -quo : quo;
      fix_hi = sign_a ? -rem : rem;
    end
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      op_r   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_zero <= 1'b0;
      a_orig <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc    <= '0;
    end else begin
      done <= (state == S_FIX);

      if (accept) begin
        op_r   <= op;
        sign_a <= in_sa;
        sign_b <= in_sb;
        b_zero <= (b == '0);
        a_orig <= a;
        mag_a  <= in_mag_a;
        mag_b  <= in_mag_b;
        cnt    <= '0;
        busy   <= 1'b1;
        acc    <= {{WIDTH{1'b0}}, (op == OP_MULT || op == OP_MULTU) ? in_mag_b : in_mag_a};
      end else if (state == S_CALC) begin
        acc <= acc_next;
        cnt <= cnt + 1'b1;
      end else if (state == S_FIX) begin
        busy <= 1'b0;
      end

      if (state == S_FIX) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end else begin
        if (mthi_we) hi <= a;
        if (mtlo_we) lo <= a;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
// Scoreboard bench for muldiv_hilo: stimulus pushes expected {hi,lo} from an
// arithmetic reference model; a negedge monitor pops on every done pulse.
module tb_muldiv_hilo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0, b = '0;
  logic [31:0] hi, lo;
  logic        busy, done;

  int checks = 0;
  int passed = 0;

  logic [63:0] expq[$];
  logic [31:0] m_hi = '0, m_lo = '0;   // model of architectural HI/LO
  logic        prev_done = 1'b0;

  muldiv_hilo #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: plain integer arithmetic, returns {hi, lo}
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          p;
    longint unsigned pu;
    int              q, r;
    logic [63:0]     res;
    res = '0;
    case (o)
      3'd1: begin p = longint'($signed(x)) * longint'($signed(y)); res = p; end
      3'd2: begin pu = {32'b0, x} * {32'b0, y}; res = pu; end
      3'd3: begin
        if (y == 0)                                   res = {x, 32'hFFFFFFFF};
        else if (x == 32'h80000000 && y == '1)        res = {32'h0, 32'h80000000};
        else begin
          q = $signed(x) / $signed(y);
          r = $signed(x) % $signed(y);
          res = {r, q};
        end
      end
      3'd4: begin
        if (y == 0) res = {x, 32'hFFFFFFFF};
        else        res = {x % y, x / y};
      end
      default: res = {m_hi, m_lo};
    endcase
    return res;
  endfunction

  // Monitor: compare on every done pulse, and insist the pulse is one cycle
  always @(negedge clk) begin
    if (prev_done) chk("done_width", {63'b0, done}, 64'd0);
    else if (done) begin
      if (expq.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
      else chk("hilo_result", {hi, lo}, expq.pop_front());
    end
    prev_done = done;
  end

  // Issue a mult/div at the current negedge; returns at the negedge where
  // busy has dropped. disturb=1 scrambles a/b/op/start during CALC.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit disturb);
    int n;
    logic [63:0] e;
    e = ref_model(o, x, y);
    expq.push_back(e);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      if (n == 16) chk("hilo_hold_during_calc", {hi, lo}, {m_hi, m_lo});
      if (disturb) begin
        a = $urandom; b = $urandom;
        op = 3'($urandom_range(1, 6)); start = 1'b1;
      end
      n++;
      @(negedge clk);
    end
    start = 1'b0; op = 3'b000;
    chk("busy_cycles", 64'(n), 64'd33);
    chk("done_at_end", {63'b0, done}, 64'd1);
    m_hi = e[63:32]; m_lo = e[31:0];
  endtask

  task automatic do_mt(input logic [2:0] o, input logic [31:0] x);
    start = 1'b1; op = o; a = x;
    @(negedge clk);
    start = 1'b0; op = 3'b000;
    if (o == 3'b101) m_hi = x;
    if (o == 3'b110) m_lo = x;
    chk("mt_hilo", {hi, lo}, {m_hi, m_lo});
    chk("mt_busy", {63'b0, busy}, 64'd0);
    chk("mt_done", {63'b0, done}, 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #100000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_state", {hi, lo, 30'b0, busy, done}, 96'd0);

    // directed cases
    do_op(3'd1, 32'hFFFFFFFD, 32'd7, 1'b0);
    do_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    do_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    do_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    do_op(3'd4, 32'd100, 32'd0, 1'b0);
    do_op(3'd3, 32'hFFFFFFF9, 32'd0, 1'b0);

    // mthi / mtlo in IDLE, then mtlo while busy is ignored (disturb ops include 6)
    do_mt(3'b101, 32'h12345678);
    do_mt(3'b110, 32'hCAFEF00D);
    do_op(3'd2, 32'd3, 32'd5, 1'b1);

    // op none / reserved: no effect
    do_mt(3'b000, 32'hDEADBEEF);
    do_mt(3'b111, 32'hDEADBEEF);

    // reset mid-flight: no done, state cleared, then normal operation
    start = 1'b1; op = 3'd1; a = 32'h1234; b = 32'h5678;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_midflight", {hi, lo, 30'b0, busy, done}, 96'd0);
    m_hi = '0; m_lo = '0;
    repeat (40) @(negedge clk);   // monitor flags any stray done here
    do_op(3'd1, 32'hFFFFFFFD, 32'd7, 1'b0);

    // randomized back-to-back traffic
    for (int i = 0; i < 24; i++)
      do_op(3'($urandom_range(1, 4)), pick(), pick(), 1'($urandom_range(0, 1)));

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(expq.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
